// File: rtl/snitch_icache_refill_handler.sv
// Refill back end of the instruction cache: returns lookup hits to the fetch
// side, tracks misses in a small pending table (merging secondary misses to
// the same line), requests refills and writes returned lines into the lookup
// banks while forwarding them to every merged requester.
module snitch_icache_refill_handler #(
  parameter int unsigned FETCH_AW      = 32,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned LINE_ALIGN    = 4,
  parameter int unsigned COUNT_ALIGN   = 5,
  parameter int unsigned SET_COUNT     = 2,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned PENDING_COUNT = 2,
  parameter int unsigned SET_ALIGN     = $clog2(SET_COUNT),
  parameter int unsigned TAG_WIDTH     = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
  parameter int unsigned PIW           = $clog2(PENDING_COUNT)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [FETCH_AW-1:0]    in_addr_i,
  input  logic [ID_WIDTH-1:0]    in_id_i,
  input  logic [SET_ALIGN-1:0]   in_set_i,
  input  logic                   in_hit_i,
  input  logic [LINE_WIDTH-1:0]  in_data_i,
  input  logic                   in_error_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_error_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [FETCH_AW-1:0]    refill_addr_o,
  output logic [PIW-1:0]         refill_id_o,
  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  input  logic [LINE_WIDTH-1:0]  refill_data_i,
  input  logic                   refill_error_i,
  input  logic [PIW-1:0]         refill_id_i,
  input  logic                   refill_valid_i,
  output logic                   refill_ready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i
);

  localparam int unsigned LAW = FETCH_AW - LINE_ALIGN;

  typedef enum logic {IDLE, BUSY} ret_state_e;

  // Pending table
  logic [PENDING_COUNT-1:0] pend_valid_q;
  logic [PENDING_COUNT-1:0] pend_ret_q;
  logic [LAW-1:0]           pend_addr_q [PENDING_COUNT];
  logic [ID_WIDTH-1:0]      pend_mask_q [PENDING_COUNT];

  // Return FSM
  ret_state_e             state_q;
  logic                   ret_ready_q;
  logic [LINE_WIDTH-1:0]  ret_data_q;
  logic                   ret_error_q;
  logic [PIW-1:0]         ret_id_q;
  logic                   write_done_q;
  logic                   rsp_done_q;
  logic [SET_ALIGN-1:0]   victim_q;

  // Output register
  logic                   rsp_valid_q;
  logic [LINE_WIDTH-1:0]  rsp_data_q;
  logic                   rsp_error_q;
  logic [ID_WIDTH-1:0]    rsp_id_q;

  logic [LAW-1:0] in_line;
  logic           match_found;
  logic [PIW-1:0] match_idx;
  logic           free_found;
  logic [PIW-1:0] free_idx;
  logic           is_hit, is_miss, merge, alloc_req, alloc_hs;
  logic           can_load, fsm_rsp_load, hit_accept;
  logic           ret_accept, write_hs, ret_exit;
  logic           unused_bits;

  assign in_line     = in_addr_i[FETCH_AW-1:LINE_ALIGN];
  assign unused_bits = ^{in_set_i, in_addr_i[LINE_ALIGN-1:0]};

  // Search the table for a mergeable entry and for the lowest free slot
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
      if (pend_valid_q[i] && !pend_ret_q[i] && pend_addr_q[i] == in_line) begin
        match_found = 1'b1;
        match_idx   = PIW'(i);
      end
      if (!pend_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PIW'(i);
      end
    end
  end

  assign is_hit       = in_valid_i & in_hit_i;
  assign is_miss      = in_valid_i & ~in_hit_i;
  assign merge        = is_miss & match_found;
  assign alloc_req    = is_miss & ~match_found & free_found;
  assign alloc_hs     = alloc_req & refill_ready_i;

  assign can_load     = ~rsp_valid_q | rsp_ready_i;
  assign fsm_rsp_load = (state_q == BUSY) & ~rsp_done_q & can_load;
  assign hit_accept   = is_hit & can_load & ~fsm_rsp_load;

  assign in_ready_o     = hit_accept | merge | alloc_hs;
  assign refill_valid_o = alloc_req;
  assign refill_addr_o  = {in_line, {LINE_ALIGN{1'b0}}};
  assign refill_id_o    = free_idx;

  assign refill_ready_o = ret_ready_q;
  assign ret_accept     = ret_ready_q & refill_valid_i;
  assign write_valid_o  = (state_q == BUSY) & ~write_done_q;
  assign write_hs       = write_valid_o & write_ready_i;
  assign ret_exit       = (state_q == BUSY) & (write_done_q | write_hs) &
                          (rsp_done_q | fsm_rsp_load);

  assign write_addr_o  = pend_addr_q[ret_id_q][COUNT_ALIGN-1:0];
  assign write_tag_o   = pend_addr_q[ret_id_q][LAW-1:COUNT_ALIGN];
  assign write_set_o   = victim_q;
  assign write_data_o  = ret_data_q;
  assign write_error_o = ret_error_q;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_id_o    = rsp_id_q;

  // Pending table: allocate on refill handshake, merge, freeze on return, free on exit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= '0;
      pend_ret_q   <= '0;
      for (int i = 0; i < PENDING_COUNT; i++) begin
        pend_addr_q[i] <= '0;
        pend_mask_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PENDING_COUNT; i++) begin
        if (ret_exit && ret_id_q == PIW'(i)) begin
          pend_valid_q[i] <= 1'b0;
          pend_ret_q[i]   <= 1'b0;
        end
        if (ret_accept && refill_id_i == PIW'(i)) begin
          pend_ret_q[i] <= 1'b1;
        end
        if (merge && match_idx == PIW'(i)) begin
          pend_mask_q[i] <= pend_mask_q[i] | in_id_i;
        end
        if (alloc_hs && free_idx == PIW'(i)) begin
          pend_valid_q[i] <= 1'b1;
          pend_ret_q[i]   <= 1'b0;
          pend_addr_q[i]  <= in_line;
          pend_mask_q[i]  <= in_id_i;
        end
      end
    end
  end

  // Return FSM: latch a refill line, then write it to the banks and respond
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ret_ready_q  <= 1'b0;
      ret_data_q   <= '0;
      ret_error_q  <= 1'b0;
      ret_id_q     <= '0;
      write_done_q <= 1'b0;
      rsp_done_q   <= 1'b0;
      victim_q     <= '0;
    end else begin
      if (write_hs) begin
        victim_q <= (victim_q == SET_ALIGN'(SET_COUNT - 1)) ? '0 : victim_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          ret_ready_q <= 1'b1;
          if (ret_accept) begin
            ret_data_q   <= refill_data_i;
            ret_error_q  <= refill_error_i;
            ret_id_q     <= refill_id_i;
            write_done_q <= 1'b0;
            rsp_done_q   <= 1'b0;
            ret_ready_q  <= 1'b0;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (write_hs)     write_done_q <= 1'b1;
          if (fsm_rsp_load) rsp_done_q   <= 1'b1;
          if (ret_exit) begin
            ret_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register: return FSM has priority over the hit path
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      rsp_id_q    <= '0;
    end else if (can_load) begin
      if (fsm_rsp_load) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= ret_data_q;
        rsp_error_q <= ret_error_q;
        rsp_id_q    <= pend_mask_q[ret_id_q];
      end else if (hit_accept) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= in_data_i;
        rsp_error_q <= in_error_i;
        rsp_id_q    <= in_id_i;
      end else begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // A refill response must name an entry that is actually pending
  refill_id_pending: assert property (
    @(posedge clk_i) disable iff (!rst_ni) ret_accept |-> pend_valid_q[refill_id_i]
  );

endmodule
